// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX pipeline register in front of the 32-bit ALU.
// Latches decoded operands, picks register or immediate for operand B and
// turns alu_op/funct3/funct7_5 into the ALU's 4-bit select code.
// Optional macro ALU_ISSUE_FWD_EN adds writeback forwarding into the operand
// latches and exposes the accepted-entry counter as issue_count.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. The producer holds its payload stable while valid is high and
// ready is low. in_ready depends on out_ready combinationally, so a full
// stage can drain and refill on the same edge with no bubble.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RDW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            use_imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic [RDW-1:0]  rd_in,
  input  logic            reg_write_in,
`ifdef ALU_ISSUE_FWD_EN
  input  logic            wb_valid,
  input  logic [RDW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic [RDW-1:0]  rs1_idx,
  input  logic [RDW-1:0]  rs2_idx,
  output logic [31:0]     issue_count,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic [3:0]      asel,
  output logic [RDW-1:0]  rd_out,
  output logic            reg_write_out,
  output logic            op_illegal
);

  localparam logic [3:0] SEL_AND = 4'b0000;
  localparam logic [3:0] SEL_OR  = 4'b0001;
  localparam logic [3:0] SEL_ADD = 4'b0010;
  localparam logic [3:0] SEL_SUB = 4'b0110;
  localparam logic [3:0] SEL_SLT = 4'b0111;
  localparam logic [3:0] SEL_NOR = 4'b1100;
  localparam logic [3:0] SEL_EQ  = 4'b1111;

  logic            valid_q;
  logic            reg_write_q;
  logic            accept;
  logic [3:0]      dec_asel;
  logic            dec_illegal;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;

  assign in_ready      = !valid_q || out_ready;
  assign accept        = in_valid && in_ready;
  assign out_valid     = valid_q;
  assign reg_write_out = reg_write_q && valid_q;

  // Decode alu_op/funct fields into the ALU select and an illegal flag.
  always_comb begin
    dec_asel    = SEL_ADD;
    dec_illegal = 1'b0;
    case (alu_op)
      2'b00: dec_asel = SEL_ADD;
      2'b01: begin
        case (funct3[2:1])
          2'b00: dec_asel = SEL_EQ;
          2'b10: dec_asel = SEL_SLT;
          2'b11: dec_asel = SEL_SUB;
          2'b01: begin
            dec_asel    = SEL_SUB;
            dec_illegal = 1'b1;
          end
        endcase
      end
      2'b10: begin
        case (funct3)
          // Bit 30 only means SUB for register-register forms; ADDI ignores it.
          3'b000:  dec_asel = (funct7_5 && !use_imm) ? SEL_SUB : SEL_ADD;
          3'b010:  dec_asel = SEL_SLT;
          3'b110:  dec_asel = SEL_OR;
          3'b111:  dec_asel = SEL_AND;
          default: begin
            dec_asel    = SEL_ADD;
            dec_illegal = 1'b1;
          end
        endcase
      end
      2'b11: dec_asel = SEL_NOR;
    endcase
  end

`ifdef ALU_ISSUE_FWD_EN
  logic        fwd_a;
  logic        fwd_b;
  logic [31:0] count_q;

  assign issue_count = count_q;

  // Bypass a same-cycle writeback into the operand latches; x0 never forwards.
  always_comb begin
    fwd_a = wb_valid && (wb_rd != '0) && (wb_rd == rs1_idx);
    fwd_b = wb_valid && (wb_rd != '0) && (wb_rd == rs2_idx);
    op_a  = fwd_a ? wb_data : rs1_data;
    op_b  = use_imm ? imm : (fwd_b ? wb_data : rs2_data);
  end

  // Count accepted entries; a flushed accept does not count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (accept && !flush) begin
      count_q <= count_q + 32'd1;
    end
  end
`else
  // Operands come straight from the register file read ports.
  always_comb begin
    op_a = rs1_data;
    op_b = use_imm ? imm : rs2_data;
  end
`endif

  // Entry register: flush wins over accept/consume, data held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      a           <= '0;
      b           <= '0;
      asel        <= SEL_ADD;
      rd_out      <= '0;
      reg_write_q <= 1'b0;
      op_illegal  <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q     <= 1'b1;
      a           <= op_a;
      b           <= op_b;
      asel        <= dec_asel;
      rd_out      <= rd_in;
      reg_write_q <= reg_write_in;
      op_illegal  <= dec_illegal;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

endmodule
